// File: rtl/data_mem_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | data_mem_arb_pkg : shared types and default widths for data_mem_arbiter  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package data_mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 19;
  localparam int unsigned DATA_W_DEF = 24;

  // Doubles as FSM state (issue owner) and as the read-return tag.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/rd_tag_pipe.sv
// +--------------------------------------------------------------------------+
// | rd_tag_pipe : DEPTH-stage shift register of read owner tags              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rd_tag_pipe
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t stage_q [DEPTH];
  owner_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= OWN_NONE;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | data_mem_arbiter : CPU/DMA arbiter for data memory port A with DMA       |
// | anti-starvation and tagged read return.  Revision: 1.0                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  owner_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  owner_t     tag_in, tag_out;
  logic       cpu_elig, dma_elig;

  // The current owner's request is the one being issued now, so it is masked.
  always_comb begin
    cpu_elig = cpu_req && (state_q != OWN_CPU);
    dma_elig = dma_req && (state_q != OWN_DMA);
    state_d  = OWN_NONE;
    if (dma_elig && (wait_q == MAX_WAIT_C)) begin
      state_d = OWN_DMA;
    end else if (cpu_elig) begin
      state_d = OWN_CPU;
    end else if (dma_elig) begin
      state_d = OWN_DMA;
    end

    wait_d = 8'd0;
    if (dma_req && (state_d != OWN_DMA)) begin
      wait_d = (wait_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OWN_NONE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_in    = OWN_NONE;
    case (state_q)
      OWN_CPU: begin
        cpu_gnt   = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        tag_in    = cpu_we ? OWN_NONE : OWN_CPU;
      end
      OWN_DMA: begin
        dma_gnt   = 1'b1;
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        tag_in    = dma_we ? OWN_NONE : OWN_DMA;
      end
      default: ;
    endcase
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_comb begin
    cpu_rvalid = (tag_out == OWN_CPU);
    dma_rvalid = (tag_out == OWN_DMA);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_data_mem_arbiter : directed self-checking bench for data_mem_arbiter  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_arbiter;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 24;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              dma_req = 1'b0, dma_we = 1'b0;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [DATA_W-1:0] dma_wdata = '0;
  logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  data_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory behind port A: RD_LAT-cycle read latency, write on issue edge.
  logic [DATA_W-1:0] tmem [int];
  logic [DATA_W-1:0] rdly [RD_LAT];
  assign mem_rdata = rdly[RD_LAT-1];
  always @(posedge clk) begin
    if (mem_we) tmem[int'(mem_addr)] = mem_wdata;
    rdly[0] <= tmem.exists(int'(mem_addr)) ? tmem[int'(mem_addr)] : '0;
    for (int i = 1; i < RD_LAT; i++) rdly[i] <= rdly[i-1];
  end

  // Reference model: who issues each cycle, DMA wait count, timestamped returns.
  typedef struct { int due; int who; logic [DATA_W-1:0] data; } rd_t;
  rd_t rq[$];
  logic [DATA_W-1:0] gold [int];
  int m_own  = 0;   // 0 none, 1 cpu, 2 dma
  int m_wait = 0;
  int mcyc   = 0;

  function automatic logic [DATA_W-1:0] gold_rd(input int a);
    return gold.exists(a) ? gold[a] : '0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_own = 0; m_wait = 0; rq.delete();
    end else begin
      int nxt;
      bit cok, dok;
      if (m_own == 1) begin
        if (cpu_we) gold[int'(cpu_addr)] = cpu_wdata;
        else rq.push_back('{mcyc + RD_LAT, 1, gold_rd(int'(cpu_addr))});
      end else if (m_own == 2) begin
        if (dma_we) gold[int'(dma_addr)] = dma_wdata;
        else rq.push_back('{mcyc + RD_LAT, 2, gold_rd(int'(dma_addr))});
      end
      cok = cpu_req && (m_own != 1);
      dok = dma_req && (m_own != 2);
      if (dok && m_wait == MAX_WAIT) nxt = 2;
      else if (cok)                  nxt = 1;
      else if (dok)                  nxt = 2;
      else                           nxt = 0;
      if (dma_req && nxt != 2) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else                     m_wait = 0;
      m_own = nxt;
      mcyc++;
      while (rq.size() > 0 && rq[0].due < mcyc) void'(rq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs",
          {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata},
          '0);
    end else begin
      bit rv;
      int who;
      logic [DATA_W-1:0] rd;
      rv  = (rq.size() > 0) && (rq[0].due == mcyc);
      who = rv ? rq[0].who : 0;
      rd  = rv ? rq[0].data : '0;
      chk("cpu_gnt", cpu_gnt, m_own == 1);
      chk("dma_gnt", dma_gnt, m_own == 2);
      chk("mem_we", mem_we, (m_own == 1) ? cpu_we : (m_own == 2) ? dma_we : 1'b0);
      chk("mem_addr", mem_addr, (m_own == 1) ? cpu_addr : (m_own == 2) ? dma_addr : '0);
      chk("mem_wdata", mem_wdata, (m_own == 1) ? cpu_wdata : (m_own == 2) ? dma_wdata : '0);
      chk("cpu_rvalid", cpu_rvalid, who == 1);
      chk("dma_rvalid", dma_rvalid, who == 2);
      chk("cpu_rdata", cpu_rdata, (who == 1) ? rd : '0);
      chk("dma_rdata", dma_rdata, (who == 2) ? rd : '0);
    end
  end

  logic [DATA_W-1:0] cpu_rx[$], dma_rx[$];
  always @(negedge clk) begin
    if (cpu_rvalid) cpu_rx.push_back(cpu_rdata);
    if (dma_rvalid) dma_rx.push_back(dma_rdata);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input int a, input logic [DATA_W-1:0] d);
    tmem[a] = d;
    gold[a] = d;
  endtask

  task automatic cpu_xfer(input logic we, input int a, input logic [DATA_W-1:0] d, output int gcyc);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = ADDR_W'(a); cpu_wdata = d;
    gcyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin gcyc = cyc; break; end
    end
    if (gcyc < 0) chk("cpu_gnt_timeout", 0, 1);
    tick();
  endtask

  task automatic dma_xfer(input logic we, input int a, input logic [DATA_W-1:0] d, output int gcyc);
    dma_req = 1'b1; dma_we = we; dma_addr = ADDR_W'(a); dma_wdata = d;
    gcyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dma_gnt) begin gcyc = cyc; break; end
    end
    if (gcyc < 0) chk("dma_gnt_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, gc, gd, raise;
    preload('h0004C, 24'hABCDEF);
    for (int i = 0; i < 4; i++) begin
      preload('h200 + i, 24'h0A0000 + 24'(i));
      preload('h300 + i, 24'h0B0000 + 24'(i));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {cpu_gnt, dma_gnt, mem_we, cpu_rvalid, dma_rvalid}, 0);
    #1 rst = 1'b1;
    tick();

    // CPU read alone
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 'h0004C;
    t0 = cyc;
    tick();
    @(negedge clk);
    chk("t1_gnt", cpu_gnt, 1);
    chk("t1_gnt_cycle", cyc - t0, 1);
    chk("t1_mem_addr", mem_addr, 'h0004C);
    tick();
    cpu_req = 1'b0;
    tick();
    @(negedge clk);
    chk("t1_rvalid", cpu_rvalid, 1);
    chk("t1_rdata", cpu_rdata, 24'hABCDEF);
    chk("t1_dma_rvalid", dma_rvalid, 0);
    tick();

    // Simultaneous writes, then readback
    fork
      begin cpu_xfer(1'b1, 'h100, 24'h111111, gc); cpu_req = 1'b0; end
      begin dma_xfer(1'b1, 'h101, 24'h222222, gd); dma_req = 1'b0; end
    join
    chk("t2_dma_after_cpu", gd - gc, 1);
    cpu_rx.delete(); dma_rx.delete();
    fork
      begin cpu_xfer(1'b0, 'h100, '0, gc); cpu_req = 1'b0; end
      begin dma_xfer(1'b0, 'h101, '0, gd); dma_req = 1'b0; end
    join
    repeat (4) tick();
    chk("t2_cpu_rd_cnt", cpu_rx.size(), 1);
    chk("t2_dma_rd_cnt", dma_rx.size(), 1);
    if (cpu_rx.size() == 1) chk("t2_cpu_readback", cpu_rx[0], 24'h111111);
    if (dma_rx.size() == 1) chk("t2_dma_readback", dma_rx[0], 24'h222222);

    // Starvation override while CPU streams reads
    fork
      begin
        for (int i = 0; i < 8; i++) cpu_xfer(1'b0, 'h200 + (i % 4), '0, gc);
        cpu_req = 1'b0;
      end
      begin
        repeat (3) tick();
        raise = cyc;
        dma_xfer(1'b0, 'h300, '0, gd);
        dma_req = 1'b0;
        chk("t3_dma_latency_ok", (gd - raise >= 1) && (gd - raise <= 4), 1);
      end
    join
    repeat (4) tick();

    // Interleaved reads
    cpu_rx.delete(); dma_rx.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) cpu_xfer(1'b0, 'h200 + i, '0, gc);
        cpu_req = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) dma_xfer(1'b0, 'h300 + i, '0, gd);
        dma_req = 1'b0;
      end
    join
    repeat (5) tick();
    chk("t4_cpu_cnt", cpu_rx.size(), 4);
    chk("t4_dma_cnt", dma_rx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cpu_rx.size()) chk("t4_cpu_data", cpu_rx[i], 24'h0A0000 + 24'(i));
      if (i < dma_rx.size()) chk("t4_dma_data", dma_rx[i], 24'h0B0000 + 24'(i));
    end

    // Reset in the cycle after a CPU read issue
    cpu_rx.delete(); dma_rx.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 'h0004C;
    tick();
    @(negedge clk);
    chk("t5_issue_gnt", cpu_gnt, 1);
    tick();
    cpu_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_async_clear",
        {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata},
        '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (5) tick();
    chk("t5_no_rvalid_after", cpu_rx.size() + dma_rx.size(), 0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 'h10; cpu_wdata = 24'h5A5A5A;
    tick();
    @(negedge clk);
    chk("t5_post_reset_gnt", cpu_gnt, 1);
    tick();
    cpu_req = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
